// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if
// Bundles the load requester port, the store requester port and the byte-wide
// single-port memory bus that the arbiter serialises them onto.
//   load port  : ld_req/ld_addr/ld_size in, ld_grant/ld_done/ld_data/ld_err out
//   store port : st_req/st_addr/st_size/st_data in, st_grant/st_done/st_err out
//   memory bus : mem_re/mem_wr/mem_address/mem_wdata out, mem_rdata in
// The slave modport is the arbiter's view; the master modport is the view of
// whatever drives the requests and models the memory.
interface mem_arbiter_if #(
    parameter int ADDR_WIDTH = 20,
    parameter int DATA_WIDTH = 32
);
    logic                  ld_req;
    logic [ADDR_WIDTH-1:0] ld_addr;
    logic [1:0]            ld_size;
    logic                  ld_grant;
    logic                  ld_done;
    logic [DATA_WIDTH-1:0] ld_data;
    logic                  ld_err;

    logic                  st_req;
    logic [ADDR_WIDTH-1:0] st_addr;
    logic [1:0]            st_size;
    logic [DATA_WIDTH-1:0] st_data;
    logic                  st_grant;
    logic                  st_done;
    logic                  st_err;

    logic                  mem_re;
    logic                  mem_wr;
    logic [ADDR_WIDTH-1:0] mem_address;
    logic [7:0]            mem_wdata;
    logic [7:0]            mem_rdata;

    modport slave (
        input  ld_req, ld_addr, ld_size,
        output ld_grant, ld_done, ld_data, ld_err,
        input  st_req, st_addr, st_size, st_data,
        output st_grant, st_done, st_err,
        output mem_re, mem_wr, mem_address, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output ld_req, ld_addr, ld_size,
        input  ld_grant, ld_done, ld_data, ld_err,
        output st_req, st_addr, st_size, st_data,
        input  st_grant, st_done, st_err,
        input  mem_re, mem_wr, mem_address, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Arbitrates a load port and a store port onto a byte-wide single-port memory.
// Each accepted request is split into 1, 2 or 4 little-endian byte beats.
// Ports:
//   clk  - single clock, rising edge
//   rst  - asynchronous, active-low reset
//   bus  - mem_arbiter_if.slave carrying both requester ports and the memory bus
// DATA_WIDTH must be at least 32 so a word transfer fits the data registers.
module mem_arbiter #(
    parameter int ADDR_WIDTH = 20,
    parameter int DATA_WIDTH = 32
) (
    input  logic           clk,
    input  logic           rst,
    mem_arbiter_if.slave   bus
);

    typedef enum logic [2:0] {IDLE, READ, RFIN, WRITE, DONE} state_t;

    state_t                state;
    logic [1:0]            beat;
    logic [1:0]            prev_beat;
    logic [1:0]            last_beat;
    logic [ADDR_WIDTH-1:0] lat_addr;
    logic [1:0]            lat_size;
    logic [DATA_WIDTH-1:0] lat_data;
    logic                  lat_st;
    logic                  last_st;
    logic [DATA_WIDTH-1:0] rd_buf;
    logic [DATA_WIDTH-1:0] rd_final;
    logic [DATA_WIDTH-1:0] ld_data_q;
    logic                  ld_err_q;
    logic                  st_err_q;

    logic                  ld_win;
    logic                  st_win;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [1:0]            sel_size;
    logic                  sel_err;

    // Illegal size or an address not aligned to the access size.
    function automatic logic size_err(input logic [1:0] size, input logic [1:0] addr_lo);
        logic err;
        case (size)
            2'b00:   err = 1'b0;
            2'b01:   err = addr_lo[0];
            2'b10:   err = (addr_lo != 2'b00);
            default: err = 1'b1;
        endcase
        return err;
    endfunction

    // Grant decision: only in IDLE and never while reset is held, so every
    // output is quiet during reset. On a tie the port not served last wins.
    always_comb begin
        ld_win = 1'b0;
        st_win = 1'b0;
        if (rst && state == IDLE) begin
            if (bus.ld_req && bus.st_req) begin
                if (last_st) ld_win = 1'b1;
                else         st_win = 1'b1;
            end else if (bus.ld_req) begin
                ld_win = 1'b1;
            end else if (bus.st_req) begin
                st_win = 1'b1;
            end
        end
    end

    // Fields of whichever port is winning this cycle.
    always_comb begin
        sel_addr = st_win ? bus.st_addr : bus.ld_addr;
        sel_size = st_win ? bus.st_size : bus.ld_size;
        sel_err  = size_err(sel_size, sel_addr[1:0]);
    end

    // Index of the final beat of the latched transfer; size 11 never gets here.
    always_comb begin
        case (lat_size)
            2'b00:   last_beat = 2'd0;
            2'b01:   last_beat = 2'd1;
            default: last_beat = 2'd3;
        endcase
        prev_beat = beat - 2'd1;
    end

    // The last read byte arrives in RFIN, so merge it straight into the
    // result rather than spending another cycle storing it in rd_buf.
    always_comb begin
        rd_final = rd_buf;
        rd_final[8*last_beat +: 8] = bus.mem_rdata;
    end

    // Main FSM. Read data returns one cycle after its strobe, so while in
    // READ the byte captured belongs to the previous beat. ld_data/ld_err and
    // st_err only change when a transfer of that port completes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            beat      <= 2'd0;
            lat_addr  <= '0;
            lat_size  <= 2'b00;
            lat_data  <= '0;
            lat_st    <= 1'b0;
            last_st   <= 1'b1;
            rd_buf    <= '0;
            ld_data_q <= '0;
            ld_err_q  <= 1'b0;
            st_err_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (ld_win || st_win) begin
                        lat_addr <= sel_addr;
                        lat_size <= sel_size;
                        lat_data <= bus.st_data;
                        lat_st   <= st_win;
                        last_st  <= st_win;
                        beat     <= 2'd0;
                        rd_buf   <= '0;
                        if (sel_err) begin
                            state <= DONE;
                            if (st_win) begin
                                st_err_q <= 1'b1;
                            end else begin
                                ld_err_q  <= 1'b1;
                                ld_data_q <= '0;
                            end
                        end else begin
                            state <= st_win ? WRITE : READ;
                        end
                    end
                end
                READ: begin
                    if (beat != 2'd0) rd_buf[8*prev_beat +: 8] <= bus.mem_rdata;
                    if (beat == last_beat) state <= RFIN;
                    else                   beat  <= beat + 2'd1;
                end
                RFIN: begin
                    ld_data_q <= rd_final;
                    ld_err_q  <= 1'b0;
                    state     <= DONE;
                end
                WRITE: begin
                    if (beat == last_beat) begin
                        st_err_q <= 1'b0;
                        state    <= DONE;
                    end else begin
                        beat <= beat + 2'd1;
                    end
                end
                DONE: begin
                    beat  <= 2'd0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Memory bus and completion pulses are pure decodes of registered state,
    // so an asynchronous reset drops them immediately.
    always_comb begin
        bus.ld_grant    = ld_win;
        bus.st_grant    = st_win;
        bus.ld_done     = (state == DONE) && !lat_st;
        bus.st_done     = (state == DONE) && lat_st;
        bus.ld_data     = ld_data_q;
        bus.ld_err      = ld_err_q;
        bus.st_err      = st_err_q;
        bus.mem_re      = (state == READ);
        bus.mem_wr      = (state == WRITE);
        bus.mem_address = '0;
        bus.mem_wdata   = 8'h00;
        if (state == READ || state == WRITE) begin
            bus.mem_address = lat_addr + {{(ADDR_WIDTH-2){1'b0}}, beat};
        end
        if (state == WRITE) begin
            bus.mem_wdata = lat_data[8*beat +: 8];
        end
    end

endmodule
